// File: rtl/reservation_station.sv
// Reservation station: buffers renamed instructions, captures operands from
// the ID packet or the CDB, and presents the oldest ready entry to one pipe.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif

package rs_pkg;
  localparam int ROB_TAG_LEN = `ROB_TAG_LEN;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } CDB_DATA;

  typedef struct packed {
    logic                   valid;
    logic [XLEN-1:0]        pc;
    logic [4:0]             alu_func;
    logic                   rd_mem;
    logic                   wr_mem;
    logic [XLEN-1:0]        rs1_value;
    logic [XLEN-1:0]        rs2_value;
  } ID_EX_PACKET;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] rob_tag_val;
    logic                   rob_tag_ready;
  } MAPTABLE_PACKET;

  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [ROB_TAG_LEN-1:0] rd_tag;
    logic [ROB_TAG_LEN-1:0] rs1_tag;
    logic [ROB_TAG_LEN-1:0] rs2_tag;
    logic [XLEN-1:0]        rs1_value;
    logic [XLEN-1:0]        rs2_value;
    ID_EX_PACKET            id_packet;
  } INSTR_READY_ENTRY;

  // Internal storage: per-operand ready flags replace the single ready bit.
  typedef struct packed {
    logic                   valid;
    logic                   rs1_rdy;
    logic                   rs2_rdy;
    logic [ROB_TAG_LEN-1:0] rd_tag;
    logic [ROB_TAG_LEN-1:0] rs1_tag;
    logic [ROB_TAG_LEN-1:0] rs2_tag;
    logic [XLEN-1:0]        rs1_value;
    logic [XLEN-1:0]        rs2_value;
    ID_EX_PACKET            id_packet;
  } rs_entry_t;
endpackage

module reservation_station
  import rs_pkg::*;
#(
  parameter bit NO_WAIT_RS2 = 1'b0,
  parameter int RS_SIZE     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  CDB_DATA                 cdb,
  input  logic                    alloc_enable,
  input  ID_EX_PACKET             id_packet_out,
  input  MAPTABLE_PACKET          maptable_packet_rs1,
  input  MAPTABLE_PACKET          maptable_packet_rs2,
  input  logic [`ROB_TAG_LEN-1:0] alloc_slot,
  input  logic                    exec_stall,
  output logic                    rs_full,
  output INSTR_READY_ENTRY        ready_inst_entry
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t [RS_SIZE-1:0]              ent_q, ent_d;
  // older_q[i][j] = 1 means entry i was allocated before entry j.
  logic [RS_SIZE-1:0][RS_SIZE-1:0]      older_q, older_d;

  logic [RS_SIZE-1:0] rdy;
  logic [RS_SIZE-1:0] oldest;
  logic [IDX_W:0]     vld_cnt;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic               free_found;
  logic [IDX_W-1:0]   alloc_idx;
  logic               do_alloc;
  logic               do_issue;
  logic               cdb_live;
  rs_entry_t          new_ent;

  // A tag-0 broadcast carries no producer and must never wake anything.
  assign cdb_live = cdb.valid && (cdb.rob_tag != '0);

  // Occupancy count, readiness vector and lowest free slot.
  always_comb begin
    vld_cnt    = '0;
    rdy        = '0;
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].valid) vld_cnt = vld_cnt + 1'b1;
      rdy[i] = ent_q[i].valid && ent_q[i].rs1_rdy && (NO_WAIT_RS2 || ent_q[i].rs2_rdy);
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end
    rs_full = (vld_cnt == (IDX_W+1)'(RS_SIZE));
  end

  // Oldest ready entry: ready and no other ready entry is older than it.
  always_comb begin
    oldest  = rdy;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++)
      for (int j = 0; j < RS_SIZE; j++)
        if (rdy[j] && older_q[j][i]) oldest[i] = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (oldest[i] && !sel_vld) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Present the selected entry, or all zeros when nothing is ready.
  always_comb begin
    ready_inst_entry = '0;
    if (sel_vld) begin
      ready_inst_entry.valid     = 1'b1;
      ready_inst_entry.ready     = 1'b1;
      ready_inst_entry.rd_tag    = ent_q[sel_idx].rd_tag;
      ready_inst_entry.rs1_tag   = ent_q[sel_idx].rs1_tag;
      ready_inst_entry.rs2_tag   = ent_q[sel_idx].rs2_tag;
      ready_inst_entry.rs1_value = ent_q[sel_idx].rs1_value;
      ready_inst_entry.rs2_value = ent_q[sel_idx].rs2_value;
      ready_inst_entry.id_packet = ent_q[sel_idx].id_packet;
    end
  end

  // Build the entry being allocated, including same-edge CDB bypass.
  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.rd_tag    = alloc_slot;
    new_ent.id_packet = id_packet_out;
    new_ent.rs1_tag   = maptable_packet_rs1.rob_tag_val;
    new_ent.rs2_tag   = maptable_packet_rs2.rob_tag_val;
    new_ent.rs1_rdy   = (maptable_packet_rs1.rob_tag_val == '0) || maptable_packet_rs1.rob_tag_ready;
    new_ent.rs2_rdy   = (maptable_packet_rs2.rob_tag_val == '0) || maptable_packet_rs2.rob_tag_ready;
    new_ent.rs1_value = id_packet_out.rs1_value;
    new_ent.rs2_value = id_packet_out.rs2_value;
    if (!new_ent.rs1_rdy && cdb_live && (cdb.rob_tag == new_ent.rs1_tag)) begin
      new_ent.rs1_rdy   = 1'b1;
      new_ent.rs1_value = cdb.value;
    end
    if (!new_ent.rs2_rdy && cdb_live && (cdb.rob_tag == new_ent.rs2_tag)) begin
      new_ent.rs2_rdy   = 1'b1;
      new_ent.rs2_value = cdb.value;
    end
  end

  assign do_alloc = alloc_enable && !rs_full;
  assign do_issue = sel_vld && !exec_stall;

  // Next state: wake-up, issue-free, then allocation into a free slot.
  always_comb begin
    ent_d   = ent_q;
    older_d = older_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].valid && cdb_live) begin
        if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb.rob_tag)) begin
          ent_d[i].rs1_rdy   = 1'b1;
          ent_d[i].rs1_value = cdb.value;
        end
        if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb.rob_tag)) begin
          ent_d[i].rs2_rdy   = 1'b1;
          ent_d[i].rs2_value = cdb.value;
        end
      end
    end
    if (do_issue) ent_d[sel_idx].valid = 1'b0;
    if (do_alloc) begin
      ent_d[alloc_idx] = new_ent;
      // New entry is younger than every currently valid entry; stale bits of
      // invalid entries are ignored because they never appear in rdy.
      for (int j = 0; j < RS_SIZE; j++) begin
        older_d[alloc_idx][j] = 1'b0;
        older_d[j][alloc_idx] = ent_q[j].valid;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q   <= '0;
      older_q <= '0;
    end else begin
      ent_q   <= ent_d;
      older_q <= older_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench: one RS configured for loads/stores, one for ALU ops.
module tb_reservation_station;
  import rs_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  CDB_DATA          cdb;
  ID_EX_PACKET      id_pkt;
  MAPTABLE_PACKET   mt1, mt2;
  logic [`ROB_TAG_LEN-1:0] slot;
  logic             alloc_ls, alloc_alu, stall_ls, stall_alu;
  logic             full_ls, full_alu;
  INSTR_READY_ENTRY out_ls, out_alu;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reservation_station #(.NO_WAIT_RS2(1'b1), .RS_SIZE(4)) dut_ls (
    .clk(clk), .reset(reset), .cdb(cdb), .alloc_enable(alloc_ls),
    .id_packet_out(id_pkt), .maptable_packet_rs1(mt1), .maptable_packet_rs2(mt2),
    .alloc_slot(slot), .exec_stall(stall_ls), .rs_full(full_ls),
    .ready_inst_entry(out_ls));

  reservation_station #(.NO_WAIT_RS2(1'b0), .RS_SIZE(4)) dut_alu (
    .clk(clk), .reset(reset), .cdb(cdb), .alloc_enable(alloc_alu),
    .id_packet_out(id_pkt), .maptable_packet_rs1(mt1), .maptable_packet_rs2(mt2),
    .alloc_slot(slot), .exec_stall(stall_alu), .rs_full(full_alu),
    .ready_inst_entry(out_alu));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input int s, input int t1, input bit r1, input int v1,
                           input int t2, input bit r2, input int v2,
                           input bit rdm, input bit wrm);
    id_pkt           = '0;
    id_pkt.valid     = 1'b1;
    id_pkt.rd_mem    = rdm;
    id_pkt.wr_mem    = wrm;
    id_pkt.rs1_value = 32'(v1);
    id_pkt.rs2_value = 32'(v2);
    mt1.rob_tag_val  = 3'(t1);
    mt1.rob_tag_ready = r1;
    mt2.rob_tag_val  = 3'(t2);
    mt2.rob_tag_ready = r2;
    slot             = 3'(s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (out_ls.valid !== 1'b0) begin errors++; $display("FAIL reset_ls_valid got=%0b exp=0", out_ls.valid); end
    checks++; if (full_ls !== 1'b0) begin errors++; $display("FAIL reset_ls_full got=%0b exp=0", full_ls); end
    checks++; if (out_alu !== '0) begin errors++; $display("FAIL reset_alu_entry got=%h exp=0", out_alu); end
  endtask

  task automatic test_issue_ld();
    set_alloc(1, 0, 0, 5, 0, 0, 0, 1, 0);
    alloc_ls = 1'b1; tick(); alloc_ls = 1'b0;
    checks++; if (out_ls.valid !== 1'b1) begin errors++; $display("FAIL ld_valid got=%0b exp=1", out_ls.valid); end
    checks++; if (out_ls.ready !== 1'b1) begin errors++; $display("FAIL ld_ready got=%0b exp=1", out_ls.ready); end
    checks++; if (out_ls.rd_tag !== 3'd1) begin errors++; $display("FAIL ld_rd_tag got=%0d exp=1", out_ls.rd_tag); end
    checks++; if (out_ls.rs1_value !== 32'd5) begin errors++; $display("FAIL ld_rs1_value got=%0d exp=5", out_ls.rs1_value); end
  endtask

  task automatic test_stall_then_st();
    stall_ls = 1'b1; tick(); stall_ls = 1'b0;
    checks++; if (out_ls.valid !== 1'b1 || out_ls.rd_tag !== 3'd1) begin errors++; $display("FAIL stall_hold got=%0b/%0d exp=1/1", out_ls.valid, out_ls.rd_tag); end
    set_alloc(3, 0, 0, 5, 2, 0, 0, 0, 1);
    alloc_ls = 1'b1; tick(); alloc_ls = 1'b0;
    checks++; if (out_ls.valid !== 1'b1) begin errors++; $display("FAIL st_valid got=%0b exp=1", out_ls.valid); end
    checks++; if (out_ls.rd_tag !== 3'd3) begin errors++; $display("FAIL st_rd_tag got=%0d exp=3", out_ls.rd_tag); end
    checks++; if (out_ls.rs1_value !== 32'd5) begin errors++; $display("FAIL st_rs1_value got=%0d exp=5", out_ls.rs1_value); end
    tick();
    checks++; if (out_ls.valid !== 1'b0) begin errors++; $display("FAIL ls_drained got=%0b exp=0", out_ls.valid); end
  endtask

  task automatic test_wakeup_bypass();
    set_alloc(2, 0, 0, 10, 1, 0, 0, 0, 0);
    alloc_alu = 1'b1; tick(); alloc_alu = 1'b0;
    checks++; if (out_alu.valid !== 1'b0) begin errors++; $display("FAIL mul_waiting got=%0b exp=0", out_alu.valid); end
    // addi allocated on the same edge as the tag-1 broadcast
    set_alloc(4, 1, 0, 0, 0, 0, 7, 0, 0);
    cdb = '{valid: 1'b1, rob_tag: 3'd1, value: 32'd5};
    alloc_alu = 1'b1; tick(); alloc_alu = 1'b0; cdb = '0;
    checks++; if (out_alu.valid !== 1'b1 || out_alu.rd_tag !== 3'd2) begin errors++; $display("FAIL mul_selected got=%0b/%0d exp=1/2", out_alu.valid, out_alu.rd_tag); end
    checks++; if (out_alu.rs2_tag !== 3'd1) begin errors++; $display("FAIL mul_rs2_tag got=%0d exp=1", out_alu.rs2_tag); end
    checks++; if (out_alu.rs2_value !== 32'd5) begin errors++; $display("FAIL mul_rs2_value got=%0d exp=5", out_alu.rs2_value); end
    checks++; if (out_alu.rs1_value !== 32'd10) begin errors++; $display("FAIL mul_rs1_value got=%0d exp=10", out_alu.rs1_value); end
    tick();
    checks++; if (out_alu.valid !== 1'b1 || out_alu.rd_tag !== 3'd4) begin errors++; $display("FAIL addi_selected got=%0b/%0d exp=1/4", out_alu.valid, out_alu.rd_tag); end
    checks++; if (out_alu.rs1_value !== 32'd5 || out_alu.rs2_value !== 32'd7) begin errors++; $display("FAIL addi_values got=%0d/%0d exp=5/7", out_alu.rs1_value, out_alu.rs2_value); end
    tick();
    checks++; if (out_alu.valid !== 1'b0) begin errors++; $display("FAIL alu_drained got=%0b exp=0", out_alu.valid); end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) begin
      set_alloc(k, 7, 0, 0, 0, 0, k, 0, 0);
      alloc_alu = 1'b1; tick();
    end
    alloc_alu = 1'b0;
    checks++; if (full_alu !== 1'b1) begin errors++; $display("FAIL full_set got=%0b exp=1", full_alu); end
    checks++; if (out_alu.valid !== 1'b0) begin errors++; $display("FAIL full_none_ready got=%0b exp=0", out_alu.valid); end
    set_alloc(5, 0, 0, 1, 0, 0, 1, 0, 0);
    alloc_alu = 1'b1; tick(); alloc_alu = 1'b0;
    checks++; if (full_alu !== 1'b1 || out_alu.valid !== 1'b0) begin errors++; $display("FAIL drop_when_full got=%0b/%0b exp=1/0", full_alu, out_alu.valid); end
    cdb = '{valid: 1'b1, rob_tag: 3'd7, value: 32'd99};
    tick(); cdb = '0;
    checks++; if (out_alu.rd_tag !== 3'd1 || out_alu.rs1_value !== 32'd99) begin errors++; $display("FAIL tag7_oldest got=%0d/%0d exp=1/99", out_alu.rd_tag, out_alu.rs1_value); end
    checks++; if (full_alu !== 1'b1) begin errors++; $display("FAIL full_before_issue got=%0b exp=1", full_alu); end
    tick();
    checks++; if (full_alu !== 1'b0) begin errors++; $display("FAIL full_after_issue got=%0b exp=0", full_alu); end
    for (int k = 2; k <= 4; k++) begin
      checks++; if (out_alu.valid !== 1'b1 || out_alu.rd_tag !== 3'(k)) begin errors++; $display("FAIL age_order got=%0b/%0d exp=1/%0d", out_alu.valid, out_alu.rd_tag, k); end
      tick();
    end
    checks++; if (out_alu.valid !== 1'b0) begin errors++; $display("FAIL dropped_not_stored got=%0b/%0d exp=0", out_alu.valid, out_alu.rd_tag); end
  endtask

  task automatic test_reset_busy();
    set_alloc(1, 3, 0, 0, 0, 0, 0, 0, 0);
    alloc_alu = 1'b1; tick();
    set_alloc(2, 0, 0, 8, 0, 0, 0, 0, 0);
    stall_alu = 1'b1; tick(); alloc_alu = 1'b0;
    checks++; if (out_alu.valid !== 1'b1 || out_alu.rd_tag !== 3'd2) begin errors++; $display("FAIL pre_reset got=%0b/%0d exp=1/2", out_alu.valid, out_alu.rd_tag); end
    reset = 1'b1; tick(); reset = 1'b0; stall_alu = 1'b0;
    checks++; if (out_alu.valid !== 1'b0 || full_alu !== 1'b0) begin errors++; $display("FAIL busy_reset got=%0b/%0b exp=0/0", out_alu.valid, full_alu); end
    cdb = '{valid: 1'b1, rob_tag: 3'd3, value: 32'd44};
    tick(); cdb = '0;
    checks++; if (out_alu.valid !== 1'b0) begin errors++; $display("FAIL cleared_entry_woke got=%0b exp=0", out_alu.valid); end
    set_alloc(6, 3, 0, 0, 0, 0, 0, 0, 0);
    alloc_alu = 1'b1; tick(); alloc_alu = 1'b0;
    cdb = '{valid: 1'b1, rob_tag: 3'd0, value: 32'd55};
    tick(); cdb = '0;
    checks++; if (out_alu.valid !== 1'b0) begin errors++; $display("FAIL tag0_wake got=%0b exp=0", out_alu.valid); end
    cdb = '{valid: 1'b1, rob_tag: 3'd3, value: 32'd66};
    tick(); cdb = '0;
    checks++; if (out_alu.valid !== 1'b1 || out_alu.rd_tag !== 3'd6 || out_alu.rs1_value !== 32'd66) begin errors++; $display("FAIL tag3_wake got=%0b/%0d/%0d exp=1/6/66", out_alu.valid, out_alu.rd_tag, out_alu.rs1_value); end
    tick();
  endtask

  initial begin
    reset = 1'b1; cdb = '0; id_pkt = '0; mt1 = '0; mt2 = '0; slot = '0;
    alloc_ls = 1'b0; alloc_alu = 1'b0; stall_ls = 1'b0; stall_alu = 1'b0;
    test_reset();
    test_issue_ld();
    test_stall_then_st();
    test_wakeup_bypass();
    test_full();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached exp=finish");
    $fatal(1);
  end
endmodule
